// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - decode-stage register decoder and RAW hazard scoreboard
// Optional stall counter output enabled by defining HAZARD_SCOREBOARD_STALL_CNT_EN.
module hazard_scoreboard #(
   parameter int REG_AW   = 3,
   parameter int DEPTH    = 3,
   parameter int FWD_MODE = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [15:0]       instr,
   input  logic              id_valid,
   input  logic              pipe_en,
   input  logic              flush,
   output logic [REG_AW-1:0] rs,
   output logic [REG_AW-1:0] rt,
   output logic              rs_valid,
   output logic              rt_valid,
   output logic              wr_valid,
   output logic [REG_AW-1:0] wr_reg,
   output logic              stall,
   output logic              sb_busy
`ifdef HAZARD_SCOREBOARD_STALL_CNT_EN
   ,
   output logic [15:0]       stall_cnt
`endif
);

   // Named opcodes that the decode table refers to individually
   localparam logic [4:0] OP_ST   = 5'b10000;
   localparam logic [4:0] OP_LD   = 5'b10001;
   localparam logic [4:0] OP_SLBI = 5'b10010;
   localparam logic [4:0] OP_STU  = 5'b10011;
   localparam logic [4:0] OP_LBI  = 5'b11000;
   localparam logic [4:0] OP_JR   = 5'b00101;
   localparam logic [4:0] OP_JAL  = 5'b00110;
   localparam logic [4:0] OP_JALR = 5'b00111;
   localparam logic [4:0] OP_R1   = 5'b11001;

   // Destination field selector
   localparam logic [2:0] WS_NONE = 3'd0;
   localparam logic [2:0] WS_RD   = 3'd1;
   localparam logic [2:0] WS_RT   = 3'd2;
   localparam logic [2:0] WS_RS   = 3'd3;
   localparam logic [2:0] WS_LINK = 3'd4;

   localparam logic [REG_AW-1:0] LINK_REG = '1;

   logic [4:0]        op;
   logic [REG_AW-1:0] f_rs;
   logic [REG_AW-1:0] f_rt;
   logic [REG_AW-1:0] f_rd;
   logic              rd_rs;
   logic              rd_rt;
   logic [2:0]        wsel;
   logic [REG_AW-1:0] dest_c;
   logic              is_load;
   logic              unused_bits;

   // Scoreboard: index 0 is the stage just after decode
   logic [DEPTH-1:0]             e_v;
   logic [DEPTH-1:0][REG_AW-1:0] e_dest;
   logic [DEPTH-1:0]             e_ld;
   logic [DEPTH-1:0]             match;
   logic                         hazard;

   assign op          = instr[15:11];
   assign f_rs        = REG_AW'(instr[10:8]);
   assign f_rt        = REG_AW'(instr[7:5]);
   assign f_rd        = REG_AW'(instr[4:2]);
   assign unused_bits = ^instr[1:0];
   assign is_load     = (op == OP_LD);

   // Opcode classification: which sources are read and where the destination lives
   always_comb begin
      rd_rs = 1'b0;
      rd_rt = 1'b0;
      wsel  = WS_NONE;
      casez (op)
         5'b010??: begin rd_rs = 1'b1; wsel = WS_RT; end
         5'b101??: begin rd_rs = 1'b1; wsel = WS_RT; end
         OP_R1:    begin rd_rs = 1'b1; wsel = WS_RD; end
         OP_LD:    begin rd_rs = 1'b1; wsel = WS_RT; end
         OP_SLBI:  begin rd_rs = 1'b1; wsel = WS_RS; end
         5'b011??: begin rd_rs = 1'b1; end
         OP_JR:    begin rd_rs = 1'b1; end
         OP_JALR:  begin rd_rs = 1'b1; wsel = WS_LINK; end
         5'b1101?: begin rd_rs = 1'b1; rd_rt = 1'b1; wsel = WS_RD; end
         5'b111??: begin rd_rs = 1'b1; rd_rt = 1'b1; wsel = WS_RD; end
         OP_ST:    begin rd_rs = 1'b1; rd_rt = 1'b1; end
         OP_STU:   begin rd_rs = 1'b1; rd_rt = 1'b1; wsel = WS_RS; end
         OP_LBI:   begin wsel = WS_RS; end
         OP_JAL:   begin wsel = WS_LINK; end
         default:  begin wsel = WS_NONE; end
      endcase
   end

   // Destination mux from the selected instruction field
   always_comb begin
      dest_c = '0;
      case (wsel)
         WS_RD:   dest_c = f_rd;
         WS_RT:   dest_c = f_rt;
         WS_RS:   dest_c = f_rs;
         WS_LINK: dest_c = LINK_REG;
         default: dest_c = '0;
      endcase
   end

   // Decode outputs read as zero when IF/ID holds no real instruction
   always_comb begin
      rs       = '0;
      rt       = '0;
      rs_valid = 1'b0;
      rt_valid = 1'b0;
      wr_valid = 1'b0;
      wr_reg   = '0;
      if (id_valid) begin
         rs       = f_rs;
         rt       = f_rt;
         rs_valid = rd_rs;
         rt_valid = rd_rt;
         wr_valid = (wsel != WS_NONE);
         wr_reg   = dest_c;
      end
   end

   // Per-entry RAW comparison against the decoded sources
   always_comb begin
      match = '0;
      for (int k = 0; k < DEPTH; k++) begin
         match[k] = e_v[k] & ((rs_valid & (e_dest[k] == rs)) |
                              (rt_valid & (e_dest[k] == rt)));
      end
   end

   // Policy select: full stall on any in-flight writer, or load-use only in stage 0
   always_comb begin
      hazard = 1'b0;
      if (FWD_MODE == 0) begin
         hazard = |match;
      end else begin
         hazard = match[0] & e_ld[0];
      end
   end

   assign stall   = id_valid & hazard & ~flush;
   assign sb_busy = |e_v;

   // Scoreboard shift: flush clears, freeze holds, otherwise decode result enters stage 0
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e_v    <= '0;
         e_dest <= '0;
         e_ld   <= '0;
      end else if (flush) begin
         e_v <= '0;
      end else if (pipe_en) begin
         for (int k = DEPTH - 1; k > 0; k--) begin
            e_v[k]    <= e_v[k-1];
            e_dest[k] <= e_dest[k-1];
            e_ld[k]   <= e_ld[k-1];
         end
         e_v[0]    <= id_valid & wr_valid & ~stall;
         e_dest[0] <= wr_reg;
         e_ld[0]   <= is_load;
      end
   end

`ifdef HAZARD_SCOREBOARD_STALL_CNT_EN
   // Saturating count of cycles lost to hazard stalls; survives flushes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
      end else if (stall && pipe_en && (stall_cnt != 16'hFFFF)) begin
         stall_cnt <= stall_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - self-checking bench for hazard_scoreboard (both forwarding policies)
module tb_hazard_scoreboard;

   localparam int DEPTH = 3;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] instr;
   logic        id_valid, pipe_en, flush;

   logic [2:0] rs0, rt0, wr0, rs1, rt1, wr1;
   logic       rsv0, rtv0, wv0, stall0, busy0;
   logic       rsv1, rtv1, wv1, stall1, busy1;
`ifdef HAZARD_SCOREBOARD_STALL_CNT_EN
   logic [15:0] cnt0, cnt1;
`endif

   int n_cmp = 0;
   int n_err = 0;

   typedef struct packed {
      logic       v;
      logic [2:0] d;
      logic       ld;
   } ent_t;

   ent_t sb0[$];
   ent_t sb1[$];

   hazard_scoreboard #(.REG_AW(3), .DEPTH(DEPTH), .FWD_MODE(0)) u0 (
      .clk(clk), .rst_n(rst_n), .instr(instr), .id_valid(id_valid),
      .pipe_en(pipe_en), .flush(flush), .rs(rs0), .rt(rt0),
      .rs_valid(rsv0), .rt_valid(rtv0), .wr_valid(wv0), .wr_reg(wr0),
      .stall(stall0), .sb_busy(busy0)
`ifdef HAZARD_SCOREBOARD_STALL_CNT_EN
      , .stall_cnt(cnt0)
`endif
   );

   hazard_scoreboard #(.REG_AW(3), .DEPTH(DEPTH), .FWD_MODE(1)) u1 (
      .clk(clk), .rst_n(rst_n), .instr(instr), .id_valid(id_valid),
      .pipe_en(pipe_en), .flush(flush), .rs(rs1), .rt(rt1),
      .rs_valid(rsv1), .rt_valid(rtv1), .wr_valid(wv1), .wr_reg(wr1),
      .stall(stall1), .sb_busy(busy1)
`ifdef HAZARD_SCOREBOARD_STALL_CNT_EN
      , .stall_cnt(cnt1)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   // Reference decode straight from the opcode tables
   function automatic void ref_decode(input logic [15:0] i, output logic r_rs, output logic r_rt,
                                      output logic w, output logic [2:0] wd);
      int op;
      op   = int'(i[15:11]);
      r_rt = op inside {26, 27, [28:31], 16, 19};
      r_rs = r_rt || (op inside {[8:11], [20:23], 25, 17, 18, [12:15], 5, 7});
      w    = 1'b1;
      if (op inside {26, 27, [28:31], 25})      wd = i[4:2];
      else if (op inside {[8:11], [20:23], 17}) wd = i[7:5];
      else if (op inside {24, 18, 19})          wd = i[10:8];
      else if (op inside {6, 7})                wd = 3'd7;
      else begin w = 1'b0; wd = 3'd0; end
   endfunction

   function automatic logic ref_hazard(input logic fwd, input logic rsv, input logic rtv,
                                       input logic [2:0] rs, input logic [2:0] rt);
      ent_t e;
      logic m;
      logic h = 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
         e = fwd ? sb1[k] : sb0[k];
         m = e.v && ((rsv && e.d == rs) || (rtv && e.d == rt));
         if (fwd) begin
            if (k == 0 && m && e.ld) h = 1'b1;
         end else if (m) begin
            h = 1'b1;
         end
      end
      return h;
   endfunction

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         instr = 16'h0000; id_valid = 1'b0; pipe_en = 1'b1; flush = 1'b0;
         @(posedge clk);
      end
   endtask

   // Hold an instruction in decode until neither DUT stalls; returns stall counts
   task automatic issue(input logic [15:0] ins, output int c0, output int c1);
      logic done = 1'b0;
      c0 = 0; c1 = 0;
      for (int i = 0; i < 20 && !done; i++) begin
         @(negedge clk);
         instr = ins; id_valid = 1'b1; pipe_en = 1'b1; flush = 1'b0;
         #1;
         if (stall0) c0++;
         if (stall1) c1++;
         done = !stall0 && !stall1;
         @(posedge clk);
      end
      n_cmp++;
      if (!done) begin
         n_err++;
         $display("FAIL issue_timeout instr=%h got=stalling required=issued", ins);
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0; instr = 16'hD94C; id_valid = 1'b0; pipe_en = 1'b1; flush = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if ({rs0, rt0, rsv0, rtv0, wv0, wr0} !== 12'h000) begin
         n_err++; $display("FAIL reset_decode got=%h required=000", {rs0, rt0, rsv0, rtv0, wv0, wr0});
      end
      id_valid = 1'b1;
      @(posedge clk); #1;
      n_cmp++;
      if ({busy0, busy1, stall0, stall1} !== 4'b0000) begin
         n_err++; $display("FAIL reset_state got=%b required=0000", {busy0, busy1, stall0, stall1});
      end
`ifdef HAZARD_SCOREBOARD_STALL_CNT_EN
      n_cmp++;
      if (cnt0 !== 16'd0) begin n_err++; $display("FAIL reset_cnt got=%0d required=0", cnt0); end
`endif
      @(negedge clk);
      rst_n = 1'b1; id_valid = 1'b0;
   endtask

   task automatic test_decode;
      logic [15:0] vec [5] = '{16'hD94C, 16'h4381, 16'h3000, 16'h0000, 16'h8960};
      logic [11:0] exp [5] = '{{3'd1, 3'd2, 3'b111, 3'd3}, {3'd3, 3'd4, 3'b101, 3'd4},
                               {3'd0, 3'd0, 3'b001, 3'd7}, 12'h000,
                               {3'd1, 3'd3, 3'b101, 3'd3}};
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         instr = vec[i]; id_valid = 1'b1; pipe_en = 1'b0; flush = 1'b0;
         #1;
         n_cmp++;
         if ({rs0, rt0, rsv0, rtv0, wv0, wr0} !== exp[i]) begin
            n_err++;
            $display("FAIL decode_%h got=%h required=%h", vec[i], {rs0, rt0, rsv0, rtv0, wv0, wr0}, exp[i]);
         end
      end
   endtask

   task automatic test_raw_full;
      int c0, c1;
      idle(4);
      issue(16'hD94C, c0, c1);
      issue(16'h4381, c0, c1);
      n_cmp++;
      if (c0 !== 3) begin n_err++; $display("FAIL raw_full_stalls got=%0d required=3", c0); end
      n_cmp++;
      if (c1 !== 0) begin n_err++; $display("FAIL raw_fwd_stalls got=%0d required=0", c1); end
      issue(16'h44A1, c0, c1);
      n_cmp++;
      if (c0 !== 3) begin n_err++; $display("FAIL raw_dest4_stalls got=%0d required=3", c0); end
   endtask

   task automatic test_load_use;
      int c0, c1;
      idle(4);
      issue(16'h8960, c0, c1);
      issue(16'h4381, c0, c1);
      n_cmp++;
      if (c1 !== 1) begin n_err++; $display("FAIL load_use_fwd got=%0d required=1", c1); end
      n_cmp++;
      if (c0 !== 3) begin n_err++; $display("FAIL load_use_full got=%0d required=3", c0); end
   endtask

   task automatic test_jal;
      int c0, c1;
      idle(4);
      issue(16'h3000, c0, c1);
      issue(16'hDF44, c0, c1);
      n_cmp++;
      if (c0 !== 3) begin n_err++; $display("FAIL jal_link_stalls got=%0d required=3", c0); end
      idle(4);
      issue(16'h3000, c0, c1);
      issue(16'h0000, c0, c1);
      n_cmp++;
      if (c0 !== 0) begin n_err++; $display("FAIL jal_halt_stalls got=%0d required=0", c0); end
   endtask

   task automatic test_flush;
      int c0, c1;
      idle(4);
      issue(16'hD94C, c0, c1);
      @(negedge clk);
      instr = 16'h4381; id_valid = 1'b1;
      #1;
      n_cmp++;
      if (stall0 !== 1'b1) begin n_err++; $display("FAIL flush_pre_stall got=%b required=1", stall0); end
      @(negedge clk);
      flush = 1'b1;
      #1;
      n_cmp++;
      if ({stall0, stall1} !== 2'b00) begin n_err++; $display("FAIL flush_stall got=%b required=00", {stall0, stall1}); end
      @(negedge clk);
      flush = 1'b0;
      #1;
      n_cmp++;
      if ({busy0, stall0} !== 2'b00) begin n_err++; $display("FAIL flush_after got=%b required=00", {busy0, stall0}); end
      @(negedge clk);
      id_valid = 1'b0;
      #1;
      n_cmp++;
      if (busy0 !== 1'b1) begin n_err++; $display("FAIL flush_issue got=%b required=1", busy0); end
   endtask

   task automatic test_freeze;
      int c0, c1;
      idle(4);
      issue(16'hD94C, c0, c1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         instr = 16'h4381; id_valid = 1'b1; pipe_en = 1'b0;
         #1;
         n_cmp++;
         if ({stall0, busy0} !== 2'b11) begin
            n_err++; $display("FAIL freeze_cyc%0d got=%b required=11", i, {stall0, busy0});
         end
      end
      issue(16'h4381, c0, c1);
      n_cmp++;
      if (c0 !== 3) begin n_err++; $display("FAIL freeze_resume got=%0d required=3", c0); end
   endtask

   task automatic test_async_reset;
      int c0, c1;
      idle(4);
      issue(16'hD94C, c0, c1);
      @(negedge clk);
      instr = 16'h4381; id_valid = 1'b1;
      #1;
      n_cmp++;
      if (stall0 !== 1'b1) begin n_err++; $display("FAIL arst_pre got=%b required=1", stall0); end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({stall0, busy0} !== 2'b00) begin n_err++; $display("FAIL arst_clear got=%b required=00", {stall0, busy0}); end
`ifdef HAZARD_SCOREBOARD_STALL_CNT_EN
      n_cmp++;
      if (cnt0 !== 16'd0) begin n_err++; $display("FAIL arst_cnt got=%0d required=0", cnt0); end
`endif
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      n_cmp++;
      if (stall0 !== 1'b0) begin n_err++; $display("FAIL arst_release got=%b required=0", stall0); end
      @(posedge clk);
   endtask

   task automatic test_random;
      logic r_rs, r_rt, w, h0, h1, e_st0, e_st1, e_b0, e_b1;
      logic [2:0] wd;
      logic [11:0] e_dec;
      ent_t n;
`ifdef HAZARD_SCOREBOARD_STALL_CNT_EN
      int e_cnt0 = 0;
`endif
      @(negedge clk);
      rst_n = 1'b0; id_valid = 1'b0; flush = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      sb0.delete(); sb1.delete();
      n = '0;
      for (int k = 0; k < DEPTH; k++) begin sb0.push_back(n); sb1.push_back(n); end
      for (int cyc = 0; cyc < 400; cyc++) begin
         @(negedge clk);
         instr    = 16'($urandom);
         id_valid = ($urandom_range(0, 9) < 8);
         pipe_en  = ($urandom_range(0, 9) < 8);
         flush    = ($urandom_range(0, 19) == 0);
         #1;
         ref_decode(instr, r_rs, r_rt, w, wd);
         if (!id_valid) begin r_rs = 0; r_rt = 0; w = 0; wd = 0; end
         e_dec = id_valid ? {instr[10:8], instr[7:5], r_rs, r_rt, w, wd} : 12'h000;
         h0 = ref_hazard(1'b0, r_rs, r_rt, instr[10:8], instr[7:5]);
         h1 = ref_hazard(1'b1, r_rs, r_rt, instr[10:8], instr[7:5]);
         e_st0 = id_valid && h0 && !flush;
         e_st1 = id_valid && h1 && !flush;
         e_b0 = 1'b0; e_b1 = 1'b0;
         foreach (sb0[k]) e_b0 |= sb0[k].v;
         foreach (sb1[k]) e_b1 |= sb1[k].v;
         n_cmp++;
         if ({rs0, rt0, rsv0, rtv0, wv0, wr0} !== e_dec) begin
            n_err++; $display("FAIL rnd_decode cyc=%0d got=%h required=%h", cyc, {rs0, rt0, rsv0, rtv0, wv0, wr0}, e_dec);
         end
         n_cmp++;
         if (stall0 !== e_st0) begin n_err++; $display("FAIL rnd_stall_full cyc=%0d got=%b required=%b", cyc, stall0, e_st0); end
         n_cmp++;
         if (stall1 !== e_st1) begin n_err++; $display("FAIL rnd_stall_fwd cyc=%0d got=%b required=%b", cyc, stall1, e_st1); end
         n_cmp++;
         if ({busy0, busy1} !== {e_b0, e_b1}) begin
            n_err++; $display("FAIL rnd_busy cyc=%0d got=%b required=%b", cyc, {busy0, busy1}, {e_b0, e_b1});
         end
`ifdef HAZARD_SCOREBOARD_STALL_CNT_EN
         n_cmp++;
         if (cnt0 !== 16'(e_cnt0)) begin n_err++; $display("FAIL rnd_cnt cyc=%0d got=%0d required=%0d", cyc, cnt0, e_cnt0); end
         if (e_st0 && pipe_en) e_cnt0++;
`endif
         @(posedge clk);
         if (flush) begin
            foreach (sb0[k]) sb0[k].v = 1'b0;
            foreach (sb1[k]) sb1[k].v = 1'b0;
         end else if (pipe_en) begin
            n.d  = wd;
            n.ld = (instr[15:11] == 5'b10001);
            n.v  = id_valid && w && !e_st0;
            sb0.push_front(n); void'(sb0.pop_back());
            n.v  = id_valid && w && !e_st1;
            sb1.push_front(n); void'(sb1.pop_back());
         end
      end
   endtask

   initial begin
      rst_n = 1'b0; instr = 16'h0000; id_valid = 1'b0; pipe_en = 1'b1; flush = 1'b0;
      test_reset();
      test_decode();
      test_raw_full();
      test_load_use();
      test_jal();
      test_flush();
      test_freeze();
      test_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
